gray_window_gen: RTL and testbench
==================================

# gray_window_gen

Builds the K×K sliding pixel window that feeds the conv engine from a raster-ordered grayscale pixel stream. Holds the previous K-1 image rows in line RAMs indexed by column and shifts one new window column per accepted pixel. Emits one flattened window per valid output position, (IMG_IN_WIDTH-K+1)×(IMG_IN_HEIGHT-K+1) windows per frame.

## Interface
- IMG_IN_WIDTH, 28, pixels per row; must be ≥ KERNEL and ≥ 2
- IMG_IN_HEIGHT, 28, rows per frame; must be ≥ KERNEL
- KERNEL, 5, window edge K
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, asynchronous assert, active-low
- din_valid  in  1  pixel present this cycle
- din_sof  in  1  qualified by din_valid; marks pixel (0,0) of a frame
- din  in  `CNN_DATA_IN_W  pixel value
- win_valid  out  1  win holds a complete window
- win  out  KERNEL*KERNEL*`CNN_DATA_IN_W  element (r,c) at bits [(r*K+c)*W +: W]; r=0 is the oldest (top) row, c=0 the leftmost column
- win_row  out  `CNN_GRAY_BUFFER_ADDR_W  output-map row of the window (top-left pixel row)
- win_col  out  `CNN_GRAY_BUFFER_ADDR_W  output-map column of the window
- frame_done  out  1  one-cycle pulse coincident with the last window of a frame

## Operation
- Counters col (0..IMG_IN_WIDTH-1) and row (0..IMG_IN_HEIGHT-1) advance only on din_valid. Col wraps to 0 and increments row. Row wraps to 0 after the last pixel of a frame.
- din_valid & din_sof forces the current pixel to position (0,0), regardless of the counter state.
- Stage 0, input cycle: issue a registered read at address col to all K-1 line RAMs. Register din, col, row and the valid flag.
- Stage 1:
  - Write: ram0[col] ← pixel and ram_i[col] ← ram_{i-1} read data, for i = 1..K-2.
  - Shift the window one column left. The new column c=K-1 is {ram_{K-2} data (r=0), …, ram0 data (r=K-2), pixel (r=K-1)}.
- Window qualification, evaluated in stage 1: win_valid ← stage1_valid & row ≥ K-1 & col ≥ K-1, with win_row = row-(K-1) and win_col = col-(K-1).
- frame_done ← win_valid condition & row = IMG_IN_HEIGHT-1 & col = IMG_IN_WIDTH-1.
- Columns with col < K-1 shift in stale data from the previous row. These are masked because win_valid stays 0 for them.
- Idle cycles (din_valid=0): counters, window, and RAM contents hold. win_valid and frame_done are 0.
- A read and a write to the same RAM address never occur in the same cycle, because consecutive pixels differ in col (width ≥ 2).

## Timing
- Latency: a pixel accepted at cycle t produces its window with win_valid high at cycle t+2.
- Throughput: one pixel per cycle, no backpressure. win_valid is a single-cycle pulse per qualifying pixel.
- Reset values:
  - win_valid=0, frame_done=0, win=0, win_row=0, win_col=0.
  - Counters and pipeline valid are 0.
  - Line RAMs are not cleared.
- Reset mid-frame: all outputs and counters clear immediately. The next accepted pixel is treated as (0,0). No window is emitted until K-1 fresh rows have been written.
- SOF mid-frame: the pipeline continues, so a window already in stage 1 is still emitted. The counters restart, and no further window appears until row ≥ K-1 again.

## Structure
- `cnn_defines.v` supplies CNN_DATA_IN_W and CNN_GRAY_BUFFER_ADDR_W. The address width must cover IMG_IN_WIDTH-1. No new shared constants are added.
- Sub-module gray_line_ram: simple dual-port RAM, IMG_IN_WIDTH×CNN_DATA_IN_W, write-enable, registered read with enable, 1-cycle read latency. Instantiated K-1 times via generate.
- The window shift register and counters live in the top level.

## Test plan
Test data for all scenarios: K=5, 28×28, CNN_DATA_IN_W=8, pixel(r,c) = (r*28+c) mod 256, din_sof on the first pixel.

- Continuous frame:
  - win_valid first rises 2 cycles after pixel (4,4).
  - That window has win(0,0)=0, win(0,4)=4, win(4,0)=112, win(4,4)=116.
  - win_row=0, win_col=0.
- Window count: exactly 576 win_valid pulses per frame and one frame_done. The last window has win_row=23, win_col=23, win(4,4)=15 (783 mod 256).
- Random din_valid gaps (≈50 % duty): the window sequence and contents are identical to the continuous case. No win_valid occurs during idle cycles.
- Back-to-back frames with din_sof: the second frame produces no window before its pixel (4,4). Its first window again has win(0,0)=0.
- rst_n asserted mid-row 10, then a new frame is sent:
  - Outputs read 0 during reset.
  - After reset, 576 correct windows are produced.
  - No window contains pre-reset data at a valid position.
- din_sof injected at pixel (15,7): the counters restart. The next win_valid follows the new frame's pixel (4,4), with correct contents.

Source files
------------

// File: rtl/gray_window_gen_pkg.sv
// Shared types for the grayscale sliding-window generator: pixel/address widths
// and the stage-1 pipeline record.
`ifndef CNN_DATA_IN_W
`define CNN_DATA_IN_W 8
`endif
`ifndef CNN_GRAY_BUFFER_ADDR_W
`define CNN_GRAY_BUFFER_ADDR_W 5
`endif

package gray_window_gen_pkg;

    localparam int PIX_W  = `CNN_DATA_IN_W;
    localparam int ADDR_W = `CNN_GRAY_BUFFER_ADDR_W;

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic  valid;
        addr_t row;
        addr_t col;
        pix_t  pix;
    } stage_t;

    function automatic addr_t wrap_inc(input addr_t v, input int unsigned last);
        return (v == addr_t'(last)) ? '0 : v + addr_t'(1);
    endfunction

endpackage

// File: rtl/gray_line_ram.sv
// One image-row line buffer: simple dual-port RAM with a registered,
// enable-gated read port (1-cycle read latency). Contents are never cleared.
module gray_line_ram
    import gray_window_gen_pkg::*;
#(
    parameter int DEPTH = 28
) (
    input  logic  clk,
    input  logic  we,
    input  addr_t waddr,
    input  pix_t  wdata,
    input  logic  re,
    input  addr_t raddr,
    output pix_t  rdata
);

    pix_t mem [DEPTH];
    pix_t rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/gray_window_gen.sv
// KxK sliding window builder over a raster grayscale stream: K-1 line RAMs hold
// previous rows, a shift register holds the window, one column per pixel.
module gray_window_gen
    import gray_window_gen_pkg::*;
#(
    parameter int IMG_IN_WIDTH  = 28,
    parameter int IMG_IN_HEIGHT = 28,
    parameter int KERNEL        = 5
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        din_valid,
    input  logic                                        din_sof,
    input  logic [`CNN_DATA_IN_W-1:0]                   din,
    output logic                                        win_valid,
    output logic [KERNEL*KERNEL*`CNN_DATA_IN_W-1:0]     win,
    output logic [`CNN_GRAY_BUFFER_ADDR_W-1:0]          win_row,
    output logic [`CNN_GRAY_BUFFER_ADDR_W-1:0]          win_col,
    output logic                                        frame_done
);

    localparam int    NRAM = KERNEL - 1;
    localparam addr_t KM1  = addr_t'(KERNEL - 1);

    addr_t  col_q, col_d, row_q, row_d;
    addr_t  cur_col, cur_row;
    stage_t s1_q, s1_d;
    pix_t   rd_data [NRAM];
    pix_t   wr_data [NRAM];
    pix_t   win_q [KERNEL][KERNEL];
    pix_t   win_d [KERNEL][KERNEL];
    logic   win_valid_q, win_valid_d;
    logic   frame_done_q, frame_done_d;
    addr_t  win_row_q, win_row_d, win_col_q, win_col_d;
    logic   qual;

    // A start-of-frame pixel overrides whatever position the counters hold.
    always_comb begin
        cur_col = (din_valid && din_sof) ? '0 : col_q;
        cur_row = (din_valid && din_sof) ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (din_valid) begin
            col_d = wrap_inc(cur_col, IMG_IN_WIDTH - 1);
            row_d = (cur_col == addr_t'(IMG_IN_WIDTH - 1)) ? wrap_inc(cur_row, IMG_IN_HEIGHT - 1)
                                                             : cur_row;
        end
        s1_d.valid = din_valid;
        s1_d.row   = cur_row;
        s1_d.col   = cur_col;
        s1_d.pix   = din;
    end

    // Line RAMs form a vertical shift chain: each row moves one RAM deeper.
    always_comb begin
        wr_data[0] = s1_q.pix;
        for (int i = 1; i < NRAM; i++) wr_data[i] = rd_data[i-1];
    end

    for (genvar i = 0; i < NRAM; i++) begin : g_line
        gray_line_ram #(.DEPTH(IMG_IN_WIDTH)) u_ram (
            .clk   (clk),
            .we    (s1_q.valid),
            .waddr (s1_q.col),
            .wdata (wr_data[i]),
            .re    (din_valid),
            .raddr (cur_col),
            .rdata (rd_data[i])
        );
    end

    always_comb begin
        win_d = win_q;
        if (s1_q.valid) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 1; c++) win_d[r][c] = win_q[r][c+1];
            end
            for (int r = 0; r < KERNEL - 1; r++) win_d[r][KERNEL-1] = rd_data[KERNEL-2-r];
            win_d[KERNEL-1][KERNEL-1] = s1_q.pix;
        end
    end

    // Columns left of K-1 carry stale previous-row data; qualification hides them.
    always_comb begin
        qual         = s1_q.valid && (s1_q.row >= KM1) && (s1_q.col >= KM1);
        win_valid_d  = qual;
        frame_done_d = qual && (s1_q.row == addr_t'(IMG_IN_HEIGHT - 1))
                            && (s1_q.col == addr_t'(IMG_IN_WIDTH - 1));
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        if (qual) begin
            win_row_d = s1_q.row - KM1;
            win_col_d = s1_q.col - KM1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            s1_q         <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL; c++) win_q[r][c] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            s1_q         <= s1_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            win_q        <= win_d;
        end
    end

    always_comb begin
        win = '0;
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) win[(r*KERNEL+c)*PIX_W +: PIX_W] = win_q[r][c];
        end
    end

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;

endmodule

// File: tb/tb_gray_window_gen.sv
// Bench for gray_window_gen: an image-array reference model predicts every
// window; a negedge monitor pops and compares whatever the DUT emits.
`ifndef CNN_DATA_IN_W
`define CNN_DATA_IN_W 8
`endif
`ifndef CNN_GRAY_BUFFER_ADDR_W
`define CNN_GRAY_BUFFER_ADDR_W 5
`endif

module tb_gray_window_gen;

    localparam int IW   = 28;
    localparam int IH   = 28;
    localparam int K    = 5;
    localparam int PW   = `CNN_DATA_IN_W;
    localparam int AW   = `CNN_GRAY_BUFFER_ADDR_W;
    localparam int WINW = K * K * PW;
    localparam int EW   = WINW + 2 * AW + 1;

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            din_valid = 1'b0;
    logic            din_sof = 1'b0;
    logic [PW-1:0]   din = '0;
    logic            win_valid;
    logic [WINW-1:0] win;
    logic [AW-1:0]   win_row;
    logic [AW-1:0]   win_col;
    logic            frame_done;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    gray_window_gen #(.IMG_IN_WIDTH(IW), .IMG_IN_HEIGHT(IH), .KERNEL(K)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din_sof    (din_sof),
        .din        (din),
        .win_valid  (win_valid),
        .win        (win),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            due_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            win_cnt = 0;
    int            fd_cnt = 0;
    bit            have_first = 0;
    logic [WINW-1:0] first_win, last_win;
    logic [AW-1:0]   first_row, first_col, last_row, last_col;

    // reference model: the image as written so far, plus raster position
    int img [IH][IW];
    int m_row = 0;
    int m_col = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_stats();
        win_cnt    = 0;
        fd_cnt     = 0;
        have_first = 0;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit v, input bit sof, input int pix);
        logic [EW-1:0] e;
        logic [PW-1:0] p;
        @(posedge clk);
        #1;
        din_valid = v;
        din_sof   = v & sof;
        din       = PW'(pix);
        if (v) begin
            if (sof) begin
                m_row = 0;
                m_col = 0;
            end
            img[m_row][m_col] = pix & 255;
            if (m_row >= K - 1 && m_col >= K - 1) begin
                e = '0;
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        p = PW'(img[m_row-(K-1)+r][m_col-(K-1)+c]);
                        e[(r*K+c)*PW +: PW] = p;
                    end
                end
                e[WINW +: AW]      = AW'(m_row - (K - 1));
                e[WINW+AW +: AW]   = AW'(m_col - (K - 1));
                e[EW-1]            = (m_row == IH - 1) && (m_col == IW - 1);
                exp_q.push_back(e);
                due_q.push_back(cyc + 2);
            end
            m_col++;
            if (m_col == IW) begin
                m_col = 0;
                m_row = (m_row == IH - 1) ? 0 : m_row + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    task automatic send_frame(input bit pattern, input int gap_pct, input int stop_at, input bit sof_first);
        int r, c, pix, g;
        for (int i = 0; i < IW * IH; i++) begin
            if (i == stop_at) break;
            g = 0;
            while (g < 4 && $urandom_range(99) < gap_pct) begin
                drive(0, 0, 0);
                g++;
            end
            r = i / IW;
            c = i % IW;
            pix = pattern ? (r * IW + c) % 256 : int'($urandom_range(255));
            drive(1, sof_first && (i == 0), pix);
        end
    endtask

    task automatic reset_checks(input string tag);
        @(negedge clk);
        check({tag, "_win_valid"}, 256'(win_valid), 256'(0));
        check({tag, "_frame_done"}, 256'(frame_done), 256'(0));
        check({tag, "_win"}, 256'(win), 256'(0));
        check({tag, "_win_row"}, 256'(win_row), 256'(0));
        check({tag, "_win_col"}, 256'(win_col), 256'(0));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] act, e;
        int            d;
        if (rst_n) begin
            if (win_valid) begin
                act = {frame_done, win_col, win_row, win};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_window: got row=%0d col=%0d at cycle %0d, required none",
                             win_row, win_col, cyc);
                end else begin
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    check("window", 256'(act), 256'(e));
                    check("win_latency_cycle", 256'(cyc), 256'(d));
                end
                win_cnt++;
                if (frame_done) fd_cnt++;
                if (!have_first) begin
                    have_first = 1;
                    first_win  = win;
                    first_row  = win_row;
                    first_col  = win_col;
                end
                last_win = win;
                last_row = win_row;
                last_col = win_col;
            end else begin
                if (frame_done) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_done_without_window: got 1 required 0 at cycle %0d", cyc);
                end
                if (due_q.size() > 0 && due_q[0] <= cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL missing_window: got win_valid=0 required 1 at cycle %0d", cyc);
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        reset_checks("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // continuous pattern frame
        clear_stats();
        send_frame(1, 0, -1, 1);
        idle(6);
        check("f1_count", 256'(win_cnt), 256'(576));
        check("f1_frame_done", 256'(fd_cnt), 256'(1));
        check("f1_first_00", 256'(first_win[0 +: PW]), 256'(0));
        check("f1_first_04", 256'(first_win[4*PW +: PW]), 256'(4));
        check("f1_first_40", 256'(first_win[20*PW +: PW]), 256'(112));
        check("f1_first_44", 256'(first_win[24*PW +: PW]), 256'(116));
        check("f1_first_rowcol", 256'({first_row, first_col}), 256'(0));
        check("f1_last_row", 256'(last_row), 256'(23));
        check("f1_last_col", 256'(last_col), 256'(23));
        check("f1_last_44", 256'(last_win[24*PW +: PW]), 256'(15));

        // ~50 % input duty
        clear_stats();
        send_frame(1, 50, -1, 1);
        idle(6);
        check("gap_count", 256'(win_cnt), 256'(576));
        check("gap_frame_done", 256'(fd_cnt), 256'(1));

        // back-to-back frames: random values then pattern
        clear_stats();
        send_frame(0, 0, -1, 1);
        send_frame(1, 0, -1, 1);
        idle(6);
        check("b2b_count", 256'(win_cnt), 256'(1152));
        check("b2b_frame_done", 256'(fd_cnt), 256'(2));
        check("b2b_last_44", 256'(last_win[24*PW +: PW]), 256'(15));

        // reset mid-row 10, then a random frame without sof
        send_frame(1, 0, 10 * IW + 13, 1);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        din_valid = 1'b0;
        din_sof   = 1'b0;
        exp_q.delete();
        due_q.delete();
        m_row = 0;
        m_col = 0;
        reset_checks("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_stats();
        send_frame(0, 20, -1, 0);
        idle(6);
        check("rst_count", 256'(win_cnt), 256'(576));
        check("rst_frame_done", 256'(fd_cnt), 256'(1));

        // sof injected at pixel (15,7)
        clear_stats();
        send_frame(1, 0, 15 * IW + 7, 1);
        send_frame(1, 0, -1, 1);
        idle(6);
        check("sof_count", 256'(win_cnt), 256'(11 * 24 + 3 + 576));
        check("sof_frame_done", 256'(fd_cnt), 256'(1));

        check("queue_drained", 256'(exp_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
